and_driver: RTL and testbench

AND_DRIVER -- requirements
Module: and_driver

---
 rtl/and_driver_if.sv | 28 ++
 rtl/and_driver.sv | 114 +++++++++++
 tb/tb_and_driver.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/and_driver_if.sv
// Bus between the masking driver and a 3-share AND responder.
// The driver owns shares, randomness and enable; the responder returns result shares and done.
interface and_driver_if;
    logic [0:2] and_a;
    logic [0:2] and_b;
    logic [0:2] and_rin;
    logic       and_enable;
    logic [0:2] and_out;
    logic       and_done;

    modport master (
        output and_a,
        output and_b,
        output and_rin,
        output and_enable,
        input  and_out,
        input  and_done
    );

    modport slave (
        input  and_a,
        input  and_b,
        input  and_rin,
        input  and_enable,
        output and_out,
        output and_done
    );
endinterface

// File: rtl/and_driver.sv
// Splits two plain bits into 3-share masked operands, runs one AND on the responder,
// and recombines the result shares; a free-running LFSR supplies the masks.
module and_driver #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            a,
    input  logic            b,
    and_driver_if.master    bus,
    output logic            busy,
    output logic            result,
    output logic            result_valid,
    output logic            error
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]       state;
    logic [15:0]      lfsr;
    logic             settle_cnt;
    logic [CNT_W-1:0] run_cnt;

    // x^16+x^14+x^13+x^11+1, shifting toward the MSB with feedback into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic unmask(input logic [0:2] s);
        return s[0] ^ s[1] ^ s[2];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            settle_cnt     <= 1'b0;
            run_cnt        <= '0;
            bus.and_a      <= 3'b000;
            bus.and_b      <= 3'b000;
            bus.and_rin    <= 3'b000;
            bus.and_enable <= 1'b0;
            busy           <= 1'b0;
            result         <= 1'b0;
            result_valid   <= 1'b0;
            error          <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            error        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // The third share is the only place the plain operand appears, and it is masked.
                        bus.and_a   <= {lfsr[0], lfsr[1], a ^ lfsr[0] ^ lfsr[1]};
                        bus.and_b   <= {lfsr[2], lfsr[3], b ^ lfsr[2] ^ lfsr[3]};
                        bus.and_rin <= {lfsr[4], lfsr[5], lfsr[6]};
                        settle_cnt  <= 1'b0;
                        busy        <= 1'b1;
                        state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Two quiet cycles let the responder pipeline fill before enable rises.
                    if (settle_cnt) begin
                        bus.and_enable <= 1'b1;
                        run_cnt        <= '0;
                        state          <= RUN;
                    end else begin
                        settle_cnt <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.and_done) begin
                        result         <= unmask(bus.and_out);
                        result_valid   <= 1'b1;
                        bus.and_enable <= 1'b0;
                        bus.and_a      <= 3'b000;
                        bus.and_b      <= 3'b000;
                        bus.and_rin    <= 3'b000;
                        state          <= FINISH;
                    end else if (run_cnt == CNT_W'(TIMEOUT)) begin
                        error          <= 1'b1;
                        bus.and_enable <= 1'b0;
                        bus.and_a      <= 3'b000;
                        bus.and_b      <= 3'b000;
                        bus.and_rin    <= 3'b000;
                        state          <= FINISH;
                    end else begin
                        run_cnt <= run_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_driver.sv
// Scoreboard bench for and_driver: stimulus pushes expected outcomes, a monitor pops them
// on every result_valid/error pulse, and a behavioural responder answers the share bus.
module tb_and_driver;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic a;
    logic b;
    logic busy;
    logic result;
    logic result_valid;
    logic error;

    and_driver_if bus();

    and_driver #(.SEED(16'hACE1), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a            (a),
        .b            (b),
        .bus          (bus),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .error        (error)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit is_err;
        bit val;
    } exp_t;

    exp_t       expq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         model_result = 1'b0;
    int         resp_done_at = 0;
    bit         noise = 1'b0;
    int         run_cyc = 0;
    logic [8:0] seen0 = '0;
    logic [8:0] seen1 = '0;
    exp_t       mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Responder: answers with fresh shares of the product on the chosen RUN cycle.
    initial begin
        logic [31:0] r;
        logic        p;
        bus.and_done = 1'b0;
        bus.and_out  = 3'b000;
        forever begin
            @(negedge clk);
            if (bus.and_enable === 1'b1) begin
                if (run_cyc == resp_done_at) begin
                    r = $urandom;
                    p = (^bus.and_a) & (^bus.and_b);
                    bus.and_done = 1'b1;
                    bus.and_out  = {r[0], r[1], p ^ r[0] ^ r[1]};
                end else begin
                    bus.and_done = 1'b0;
                    bus.and_out  = 3'($urandom);
                end
                run_cyc++;
            end else begin
                run_cyc      = 0;
                bus.and_done = noise;
                bus.and_out  = 3'($urandom);
            end
        end
    end

    // Monitor: every pulse must match the oldest outstanding expectation.
    initial forever begin
        @(negedge clk);
        if (result_valid === 1'b1 || error === 1'b1) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: rv=%0b err=%0b, required no pulse", result_valid, error);
            end else begin
                mon_e = expq.pop_front();
                if (mon_e.is_err) begin
                    check("error_pulse", 32'({result_valid, error}), 32'(2'b01));
                    check("result_held", 32'(result), 32'(model_result));
                end else begin
                    check("valid_pulse", 32'({result_valid, error}), 32'(2'b10));
                    check("result_value", 32'(result), 32'(mon_e.val));
                    model_result = mon_e.val;
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: busy=%0b after 100 cycles, required 0", name, busy);
        end
    endtask

    task automatic do_op(input bit ia, input bit ib, input int done_at, input bit spam);
        int         n;
        int         lat_exp;
        bit         ok;
        logic [0:2] sa;
        logic [0:2] sb;
        logic [0:2] sr;
        exp_t       e;
        wait_idle("idle_before_op");
        ok           = (done_at <= 15);
        lat_exp      = ok ? 4 + done_at : 19;
        resp_done_at = done_at;
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        a        = 1'($urandom);
        b        = 1'($urandom);
        e.is_err = !ok;
        e.val    = ia & ib;
        expq.push_back(e);
        check("accept_busy", 32'(busy), 32'(1));
        sa = bus.and_a;
        sb = bus.and_b;
        sr = bus.and_rin;
        check("share_a_xor", 32'(^sa), 32'(ia));
        check("share_b_xor", 32'(^sb), 32'(ib));
        seen1 = seen1 | {sa, sb, sr};
        seen0 = seen0 | ~{sa, sb, sr};
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            start = (spam && (n + 1 < lat_exp)) ? 1'($urandom) : 1'b0;
            a     = 1'($urandom);
            b     = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
            if (n == 1) check("settle_enable", 32'(bus.and_enable), 32'(0));
            if (n == 2) begin
                check("run_enable", 32'(bus.and_enable), 32'(1));
                check("shares_stable", 32'({bus.and_a, bus.and_b, bus.and_rin}), 32'({sa, sb, sr}));
            end
            if (n == lat_exp - 1)
                check("pulse_timing", 32'({result_valid, error}), ok ? 32'(2'b10) : 32'(2'b01));
        end
        start = 1'b0;
        check("busy_latency", 32'(n), 32'(lat_exp));
        check("shares_cleared", 32'({bus.and_a, bus.and_b, bus.and_rin}), 32'(0));
        check("enable_idle", 32'(bus.and_enable), 32'(0));
    endtask

    initial begin
        int   n;
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({busy, result, result_valid, error, bus.and_enable}), 32'(0));
        check("rst_shares", 32'({bus.and_a, bus.and_b, bus.and_rin}), 32'(0));
        check("rst_lfsr", 32'(dut.lfsr), 32'(16'hACE1));
        @(negedge clk);
        rst = 1'b0;

        do_op(1'b1, 1'b1, 2, 1'b0);

        for (int i = 0; i < 64; i++)
            do_op(i[0], i[1], $urandom_range(0, 5), 1'b0);
        check("share_toggle", 32'(seen0 & seen1), 32'(9'h1FF));

        do_op(1'($urandom), 1'($urandom), 40, 1'b0);
        do_op(1'b1, 1'b1, 1, 1'b0);
        do_op(1'b0, 1'b1, 40, 1'b0);
        do_op(1'b1, 1'b1, 15, 1'b0);

        for (int i = 0; i < 4; i++)
            do_op(1'($urandom), 1'($urandom), $urandom_range(0, 6), 1'b1);

        noise = 1'b1;
        repeat (4) @(negedge clk);
        do_op(1'b1, 1'b1, 0, 1'b0);
        noise = 1'b0;

        // Abort an operation on RUN cycle 1 with an asynchronous reset.
        wait_idle("idle_before_abort");
        resp_done_at = 100;
        @(negedge clk);
        a     = 1'b1;
        b     = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_enable", 32'(bus.and_enable), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_lfsr", 32'(dut.lfsr), 32'(16'hACE1));
        model_result = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_pulse", 32'({result_valid, error, result}), 32'(0));
        check("abort_lfsr_held", 32'(dut.lfsr), 32'(16'hACE1));
        @(negedge clk);
        rst          = 1'b0;
        a            = 1'b1;
        b            = 1'b0;
        start        = 1'b1;
        resp_done_at = 1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        e.is_err = 1'b0;
        e.val    = 1'b0;
        expq.push_back(e);
        check("post_rst_accept", 32'(busy), 32'(1));
        check("post_rst_and_a", 32'(bus.and_a), 32'(3'b100));
        check("post_rst_and_b", 32'(bus.and_b), 32'(3'b000));
        check("post_rst_and_rin", 32'(bus.and_rin), 32'(3'b011));
        wait_idle("idle_after_rst_op");

        n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(expq.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
